// File: rtl/oc8051_ia_log_pkg.sv
// oc8051_ia_log_pkg
//  Shared definitions for the illegal-access log: register window offsets,
//  event type encodings, the processor source id and the layout of one
//  queued event.
//  No ports (package).
package oc8051_ia_log_pkg;

   // Register offsets inside the 8-byte window
   localparam logic [2:0] LOG_OFS_STATUS  = 3'd0;
   localparam logic [2:0] LOG_OFS_HEAD    = 3'd1;
   localparam logic [2:0] LOG_OFS_ADDR_HI = 3'd2;
   localparam logic [2:0] LOG_OFS_ADDR_LO = 3'd3;
   localparam logic [2:0] LOG_OFS_PC_HI   = 3'd4;
   localparam logic [2:0] LOG_OFS_PC_LO   = 3'd5;
   localparam logic [2:0] LOG_OFS_POP     = 3'd6;
   localparam logic [2:0] LOG_OFS_RSVD    = 3'd7;

   // Event type encodings carried on ia_rwn
   localparam logic [1:0] IA_RWN_WR = 2'b01;
   localparam logic [1:0] IA_RWN_RD = 2'b10;

   // Accesser id of processor 0
   localparam logic [2:0] PROC0_IA = 3'd5;

   // One logged event; packs to 37 bits, rwn in the top bits
   typedef struct packed {
      logic [1:0]  rwn;
      logic [15:0] addr;
      logic [2:0]  src;
      logic [15:0] pc;
   } ia_entry_t;

   localparam int IA_ENTRY_W = $bits(ia_entry_t);

endpackage

// File: rtl/oc8051_ia_fifo.sv
// oc8051_ia_fifo
//  Generic synchronous FIFO with first-word-fall-through head output.
//  Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push, din       write request and data; accepted when not full, or when
//                   a valid pop happens on the same edge
//   pop             read request; ignored while empty
//   full, empty     occupancy flags
//   count           number of stored entries (log2(DEPTH)+1 bits)
//   head            oldest entry (undefined while empty)
module oc8051_ia_fifo #(
   parameter int WIDTH = 37,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic [WIDTH-1:0]         head
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));
   assign head  = mem[rd_ptr];

   // A pop frees a slot in the same edge, so a full FIFO can still take a push then
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset; occupancy is tracked by the pointers and count
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/oc8051_ia_log.sv
// oc8051_ia_log
//  Queues illegal XRAM access events, raises an interrupt to the privileged
//  processor and exposes the queue head through an 8-byte XRAM window.
//  Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   ia_valid/ia_rwn/ia_addr/
//   ia_src/ia_pc                 one-cycle event from the page-table detector
//   xram_addr/xram_data_in/
//   xram_wr/log_stb/priv_lvl     bus access into the register window
//   log_addr_range               xram_addr falls inside the window
//   log_ack                      strobe acknowledge (combinational)
//   log_data_out                 read data (combinational)
//   int_req                      registered interrupt request
//   overflow                     sticky: an event was dropped while full
module oc8051_ia_log
   import oc8051_ia_log_pkg::*;
#(
   parameter int          DEPTH     = 4,
   parameter logic [15:0] BASE_ADDR = 16'hffc8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ia_valid,
   input  logic [1:0]  ia_rwn,
   input  logic [15:0] ia_addr,
   input  logic [2:0]  ia_src,
   input  logic [15:0] ia_pc,
   input  logic [15:0] xram_addr,
   input  logic [7:0]  xram_data_in,
   input  logic        xram_wr,
   input  logic        log_stb,
   input  logic        priv_lvl,
   output logic        log_addr_range,
   output logic        log_ack,
   output logic [7:0]  log_data_out,
   output logic        int_req,
   output logic        overflow
);

   localparam int CW = $clog2(DEPTH) + 1;

   ia_entry_t     new_entry;
   ia_entry_t     head;
   logic          full;
   logic          empty;
   logic [CW-1:0] count;
   logic [CW-1:0] count_next;
   logic [4:0]    count_ext;
   logic [2:0]    ofs;
   logic          bus_wr;
   logic          status_wr;
   logic          pop_req;
   logic          pop_acc;
   logic          push_acc;
   logic          drop;
   logic          overflow_next;
   logic          int_en;

   assign ofs            = xram_addr[2:0];
   assign log_addr_range = (xram_addr[15:3] == BASE_ADDR[15:3]);
   assign log_ack        = log_stb & log_addr_range;

   // Non-privileged writes are acknowledged but have no effect
   assign bus_wr    = log_ack & xram_wr & priv_lvl;
   assign status_wr = bus_wr & (ofs == LOG_OFS_STATUS);
   assign pop_req   = bus_wr & (ofs == LOG_OFS_POP);

   // Mirror of the FIFO acceptance rules, needed for the look-ahead interrupt
   assign pop_acc  = pop_req & ~empty;
   assign push_acc = ia_valid & (~full | pop_acc);
   assign drop     = ia_valid & full & ~pop_acc;

   assign new_entry = '{rwn: ia_rwn, addr: ia_addr, src: ia_src, pc: ia_pc};

   oc8051_ia_fifo #(
      .WIDTH (IA_ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (ia_valid),
      .pop   (pop_req),
      .din   (new_entry),
      .full  (full),
      .empty (empty),
      .count (count),
      .head  (head)
   );

   // Occupancy after this edge, so int_req can follow it without lag
   always_comb begin
      count_next = count;
      case ({push_acc, pop_acc})
         2'b10:   count_next = count + CW'(1);
         2'b01:   count_next = count - CW'(1);
         default: count_next = count;
      endcase
   end

   // A dropped event wins over a same-edge overflow clear
   assign overflow_next = drop ? 1'b1 : ((status_wr & xram_data_in[7]) ? 1'b0 : overflow);

   // Control/status registers and the interrupt request
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow <= 1'b0;
         int_en   <= 1'b0;
         int_req  <= 1'b0;
      end else begin
         overflow <= overflow_next;
         if (status_wr) int_en <= xram_data_in[4];
         int_req  <= int_en & ((count_next != '0) | overflow_next);
      end
   end

   assign count_ext = 5'(count);

   // Read mux; head fields read as zero while the queue is empty
   always_comb begin
      log_data_out = 8'h00;
      if (log_ack && priv_lvl) begin
         case (ofs)
            LOG_OFS_STATUS:  log_data_out = {overflow, 2'b00, int_en, count_ext[3:0]};
            LOG_OFS_HEAD:    log_data_out = empty ? 8'h00 : {head.src, 3'b000, head.rwn};
            LOG_OFS_ADDR_HI: log_data_out = empty ? 8'h00 : head.addr[15:8];
            LOG_OFS_ADDR_LO: log_data_out = empty ? 8'h00 : head.addr[7:0];
            LOG_OFS_PC_HI:   log_data_out = empty ? 8'h00 : head.pc[15:8];
            LOG_OFS_PC_LO:   log_data_out = empty ? 8'h00 : head.pc[7:0];
            default:         log_data_out = 8'h00;
         endcase
      end
   end

endmodule

// File: tb/tb_oc8051_ia_log.sv
// tb_oc8051_ia_log
//  Directed and randomized bench for the illegal-access log. A queue-based
//  reference model tracks the expected log contents, overflow, int_en and
//  int_req; every register of the window is compared against it.
module tb_oc8051_ia_log;

   localparam int          DEPTH = 4;
   localparam logic [15:0] BASE  = 16'hffc8;

   logic        clk;
   logic        rst;
   logic        ia_valid;
   logic [1:0]  ia_rwn;
   logic [15:0] ia_addr;
   logic [2:0]  ia_src;
   logic [15:0] ia_pc;
   logic [15:0] xram_addr;
   logic [7:0]  xram_data_in;
   logic        xram_wr;
   logic        log_stb;
   logic        priv_lvl;
   logic        log_addr_range;
   logic        log_ack;
   logic [7:0]  log_data_out;
   logic        int_req;
   logic        overflow;

   int checks;
   int fails;

   // Reference model state
   logic [36:0] mq[$];
   bit          m_ovf;
   bit          m_inten;
   bit          m_intreq;

   oc8051_ia_log #(
      .DEPTH     (DEPTH),
      .BASE_ADDR (BASE)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .ia_valid       (ia_valid),
      .ia_rwn         (ia_rwn),
      .ia_addr        (ia_addr),
      .ia_src         (ia_src),
      .ia_pc          (ia_pc),
      .xram_addr      (xram_addr),
      .xram_data_in   (xram_data_in),
      .xram_wr        (xram_wr),
      .log_stb        (log_stb),
      .priv_lvl       (priv_lvl),
      .log_addr_range (log_addr_range),
      .log_ack        (log_ack),
      .log_data_out   (log_data_out),
      .int_req        (int_req),
      .overflow       (overflow)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic idle();
      ia_valid     = 1'b0;
      ia_rwn       = 2'b00;
      ia_addr      = 16'h0000;
      ia_src       = 3'd0;
      ia_pc        = 16'h0000;
      xram_addr    = 16'h0000;
      xram_data_in = 8'h00;
      xram_wr      = 1'b0;
      log_stb      = 1'b0;
      priv_lvl     = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         fails++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drives one clock of stimulus (optional event, optional bus write), then updates the model
   task automatic applyStimulus(input logic v, input logic [1:0] rwn, input logic [15:0] a,
                                input logic [2:0] s, input logic [15:0] pc, input logic bw,
                                input logic [2:0] ofs, input logic [7:0] d, input logic pr);
      bit pop_ok;
      bit st_wr;
      bit drop;
      ia_valid = v;
      ia_rwn   = rwn;
      ia_addr  = a;
      ia_src   = s;
      ia_pc    = pc;
      if (bw) begin
         log_stb      = 1'b1;
         xram_wr      = 1'b1;
         xram_addr    = BASE | {13'd0, ofs};
         xram_data_in = d;
         priv_lvl     = pr;
      end
      @(posedge clk);
      pop_ok = bw && pr && (ofs == 3'd6) && (mq.size() > 0);
      st_wr  = bw && pr && (ofs == 3'd0);
      drop   = 1'b0;
      if (pop_ok) mq.delete(0);
      if (v) begin
         if (mq.size() < DEPTH) mq.push_back({rwn, a, s, pc});
         else drop = 1'b1;
      end
      if (drop) m_ovf = 1'b1;
      else if (st_wr && d[7]) m_ovf = 1'b0;
      m_intreq = m_inten && (mq.size() != 0 || m_ovf);
      if (st_wr) m_inten = d[4];
      #1;
      idle();
   endtask

   task automatic pushEvent(input logic [1:0] rwn, input logic [15:0] a, input logic [2:0] s,
                            input logic [15:0] pc);
      applyStimulus(1'b1, rwn, a, s, pc, 1'b0, 3'd0, 8'h00, 1'b1);
   endtask

   task automatic busWrite(input logic [2:0] ofs, input logic [7:0] d, input logic pr);
      applyStimulus(1'b0, 2'b00, 16'h0, 3'd0, 16'h0, 1'b1, ofs, d, pr);
   endtask

   task automatic readReg(input logic [2:0] ofs, input logic pr, output logic [7:0] d,
                          output logic ack);
      xram_addr = BASE | {13'd0, ofs};
      xram_wr   = 1'b0;
      log_stb   = 1'b1;
      priv_lvl  = pr;
      #1;
      d   = log_data_out;
      ack = log_ack;
      log_stb  = 1'b0;
      priv_lvl = 1'b0;
   endtask

   // Compares all eight window registers plus int_req/overflow against the model
   task automatic checkAll(input string tag);
      logic [7:0]  e [8];
      logic [36:0] h;
      logic [7:0]  d;
      logic        ack;
      int          n;
      n    = mq.size();
      e[0] = {m_ovf, 2'b00, m_inten, 4'(n)};
      for (int i = 1; i < 8; i++) e[i] = 8'h00;
      if (n > 0) begin
         h    = mq[0];
         e[1] = {h[18:16], 3'b000, h[36:35]};
         e[2] = h[34:27];
         e[3] = h[26:19];
         e[4] = h[15:8];
         e[5] = h[7:0];
      end
      for (int i = 0; i < 8; i++) begin
         readReg(3'(i), 1'b1, d, ack);
         checkOutput($sformatf("%s reg%0d", tag, i), {8'h00, d}, {8'h00, e[i]});
      end
      checkOutput({tag, " ack"}, {15'd0, ack}, 16'd1);
      checkOutput({tag, " int_req"}, {15'd0, int_req}, {15'd0, m_intreq});
      checkOutput({tag, " overflow"}, {15'd0, overflow}, {15'd0, m_ovf});
   endtask

   task automatic readExpect(input string tag, input logic [2:0] ofs, input logic [7:0] exp);
      logic [7:0] d;
      logic       ack;
      readReg(ofs, 1'b1, d, ack);
      checkOutput(tag, {8'h00, d}, {8'h00, exp});
   endtask

   initial begin
      logic [7:0] d;
      logic       ack;
      checks   = 0;
      fails    = 0;
      m_ovf    = 1'b0;
      m_inten  = 1'b0;
      m_intreq = 1'b0;
      rst      = 1'b1;
      idle();
      repeat (2) @(posedge clk);
      #1;

      // Reset state
      checkOutput("reset int_req", {15'd0, int_req}, 16'd0);
      checkOutput("reset overflow", {15'd0, overflow}, 16'd0);
      checkOutput("reset data idle", {8'h00, log_data_out}, 16'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      checkAll("reset");

      // Out-of-window address is not acknowledged
      xram_addr = 16'hffc0;
      log_stb   = 1'b1;
      priv_lvl  = 1'b1;
      #1;
      checkOutput("range outside", {15'd0, log_addr_range}, 16'd0);
      checkOutput("ack outside", {15'd0, log_ack}, 16'd0);
      idle();

      // Test 1: single event
      $display("[TB] test 1: single event");
      pushEvent(2'b01, 16'h1234, 3'd5, 16'h0a0b);
      readExpect("t1 status", 3'd0, 8'h01);
      readExpect("t1 head", 3'd1, 8'ha1);
      readExpect("t1 addr hi", 3'd2, 8'h12);
      readExpect("t1 addr lo", 3'd3, 8'h34);
      readExpect("t1 pc hi", 3'd4, 8'h0a);
      readExpect("t1 pc lo", 3'd5, 8'h0b);
      checkAll("t1");
      busWrite(3'd6, 8'h00, 1'b1);
      checkAll("t1 pop");

      // Test 2: interrupt with three events
      $display("[TB] test 2: interrupt");
      busWrite(3'd0, 8'h10, 1'b1);
      checkAll("t2 int_en");
      pushEvent(2'b10, 16'h0100, 3'd1, 16'h0000);
      checkOutput("t2 int_req rise", {15'd0, int_req}, 16'd1);
      pushEvent(2'b01, 16'h0200, 3'd2, 16'h0000);
      pushEvent(2'b10, 16'h0300, 3'd0, 16'h5555);
      checkAll("t2 three");
      for (int i = 0; i < 3; i++) begin
         busWrite(3'd6, 8'hff, 1'b1);
         checkAll($sformatf("t2 pop%0d", i));
      end
      checkOutput("t2 int_req fall", {15'd0, int_req}, 16'd0);
      readExpect("t2 status", 3'd0, 8'h10);

      // Test 3: overflow with five events
      $display("[TB] test 3: overflow");
      for (int i = 0; i < 5; i++) pushEvent(2'b01, 16'h1000 + 16'(i), 3'(i + 1), 16'h2000 + 16'(i));
      readExpect("t3 status full", 3'd0, 8'h94);
      readExpect("t3 head addr lo", 3'd3, 8'h00);
      checkAll("t3 full");
      busWrite(3'd0, 8'h90, 1'b1);
      readExpect("t3 status clr", 3'd0, 8'h14);
      checkAll("t3 clr");

      // Test 4: full FIFO, same-edge push and pop
      $display("[TB] test 4: push+pop when full");
      applyStimulus(1'b1, 2'b10, 16'hbeef, 3'd3, 16'hcafe, 1'b1, 3'd6, 8'h00, 1'b1);
      readExpect("t4 status", 3'd0, 8'h14);
      checkAll("t4");
      for (int i = 0; i < 4; i++) begin
         if (i == 3) readExpect("t4 last addr hi", 3'd2, 8'hbe);
         busWrite(3'd6, 8'h00, 1'b1);
         checkAll($sformatf("t4 drain%0d", i));
      end

      // Test 5: non-privileged access
      $display("[TB] test 5: non-privileged");
      for (int i = 0; i < 5; i++) pushEvent(2'b01, 16'h4000 + 16'(i), 3'd4, 16'h0);
      busWrite(3'd6, 8'h00, 1'b0);
      busWrite(3'd0, 8'h80, 1'b0);
      for (int i = 0; i < 8; i++) begin
         readReg(3'(i), 1'b0, d, ack);
         checkOutput($sformatf("t5 np data%0d", i), {8'h00, d}, 16'd0);
         checkOutput($sformatf("t5 np ack%0d", i), {15'd0, ack}, 16'd1);
      end
      checkAll("t5 unchanged");
      // Overflow clear racing a dropped push: set wins
      applyStimulus(1'b1, 2'b01, 16'h7777, 3'd1, 16'h0, 1'b1, 3'd0, 8'h90, 1'b1);
      checkAll("t5 set wins");

      // Test 6: asynchronous reset mid-cycle, then pointer wrap
      $display("[TB] test 6: async reset and wrap");
      busWrite(3'd0, 8'h80, 1'b1);
      for (int i = 0; i < 4; i++) busWrite(3'd6, 8'h00, 1'b1);
      busWrite(3'd0, 8'h10, 1'b1);
      pushEvent(2'b01, 16'h0011, 3'd1, 16'h0);
      pushEvent(2'b01, 16'h0022, 3'd2, 16'h0);
      checkAll("t6 pre-reset");
      #4;
      rst = 1'b1;
      #1;
      checkOutput("t6 async int_req", {15'd0, int_req}, 16'd0);
      mq.delete();
      m_ovf    = 1'b0;
      m_inten  = 1'b0;
      m_intreq = 1'b0;
      readExpect("t6 async status", 3'd0, 8'h00);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      busWrite(3'd6, 8'h00, 1'b1);
      checkAll("t6 empty pop");
      busWrite(3'd0, 8'h10, 1'b1);
      for (int i = 0; i < 6; i++) begin
         pushEvent(2'(i + 1), 16'h8000 + 16'(i * 3), 3'(i), 16'h9000 + 16'(i));
         checkAll($sformatf("t6 ev%0d", i));
         if (i % 2 == 1) begin
            busWrite(3'd6, 8'h00, 1'b1);
            checkAll($sformatf("t6 pop%0d", i));
         end
      end

      // Randomized traffic
      $display("[TB] random phase");
      for (int n = 0; n < 200; n++) begin
         logic       v;
         logic       bw;
         logic [2:0] ofs;
         logic [7:0] wd;
         logic       pr;
         v   = 1'($urandom_range(0, 1));
         bw  = ($urandom_range(0, 2) != 0);
         ofs = ($urandom_range(0, 4) == 0) ? 3'd0 : (($urandom_range(0, 9) == 0) ? 3'd7 : 3'd6);
         wd  = 8'($urandom);
         pr  = ($urandom_range(0, 5) != 0);
         applyStimulus(v, 2'($urandom), 16'($urandom), 3'($urandom), 16'($urandom),
                       bw, ofs, wd, pr);
         checkAll($sformatf("rand%0d", n));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
